// File: rtl/ddr3_seq_pkg.sv
// ddr3_seq_pkg
// Shared definitions for the DDR3 request sequencer: controller command
// encodings, the sequencer FSM state type and the user-interface widths.
package ddr3_seq_pkg;

   localparam logic [2:0] CMD_WRITE = 3'b000;
   localparam logic [2:0] CMD_READ  = 3'b001;

   // One BL8 burst moves as two 256-bit beats on the user interface.
   localparam int BEATS_PER_BURST = 2;

   localparam int DATA_W = 256;
   localparam int MASK_W = 32;

   typedef enum logic [2:0] {
      IDLE,
      WBEAT0,
      WBEAT1,
      WCMD,
      RCMD
   } seq_state_t;

endpackage

// File: rtl/ddr3_resp_fifo.sv
// ddr3_resp_fifo
// Synchronous response buffer for read beats returned by the controller.
// Pointer based with an occupancy count; a pop frees its slot in the same
// cycle, so a push into a full FIFO is accepted when a pop happens with it.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   push/push_data  write side; a push that finds no room is dropped
//   pop/pop_data    read side; pop_data is the oldest entry (first word)
//   full/empty      occupancy flags
//   count           number of stored beats, 0..DEPTH
module ddr3_resp_fifo
   import ddr3_seq_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] pop_data,
   output logic              full,
   output logic              empty,
   output logic [CNT_W-1:0]  count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign empty    = (count == '0);
   assign full     = (count == CNT_W'(DEPTH));
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign pop_data = mem[rd_ptr];

   // NOTE: the storage array has no reset; validity is carried entirely by
   // the pointers and count, and leaving it unreset lets it map to RAM.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/ddr3_req_sequencer.sv
// ddr3_req_sequencer
// Drives the DDR3 controller user interface from a ready/valid command
// stream and a write-data stream. Writes pass two beats straight through
// (never buffered here) and then issue the command; reads issue the command
// after reserving two response-FIFO credits, because the controller's read
// data port cannot be stalled.
// Ports:
//   user_clock, user_reset                 clock, synchronous active-high reset
//   req_valid/req_write/req_addr/req_ready command request stream
//   wdata_valid/wdata/wmask/wdata_ready    write beat stream
//   resp_valid/resp_data/resp_ready        read beat stream (arrival order)
//   resp_overflow                          sticky: a read beat was dropped
//   app_cmd/app_enable/app_addr/app_ready  controller command handshake
//   app_wdf_*                              controller write-data handshake
//   app_rd_ready/app_rd_data               controller read data (no backpressure)
//   init_done                              controller calibration complete
module ddr3_req_sequencer
   import ddr3_seq_pkg::*;
#(
   parameter int RESP_DEPTH = 16,
   parameter int ADDR_W     = 27
) (
   input  logic              user_clock,
   input  logic              user_reset,
   input  logic              req_valid,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              req_ready,
   input  logic              wdata_valid,
   input  logic [DATA_W-1:0] wdata,
   input  logic [MASK_W-1:0] wmask,
   output logic              wdata_ready,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_data,
   input  logic              resp_ready,
   output logic              resp_overflow,
   output logic [2:0]        app_cmd,
   output logic              app_enable,
   output logic [ADDR_W-1:0] app_addr,
   input  logic              app_ready,
   output logic              app_wdf_enable,
   output logic [DATA_W-1:0] app_wdf_data,
   output logic [MASK_W-1:0] app_wdf_mask,
   output logic              app_wdf_end,
   input  logic              app_wdf_ready,
   input  logic              app_rd_ready,
   input  logic [DATA_W-1:0] app_rd_data,
   input  logic              init_done
);

   localparam int CNT_W = $clog2(RESP_DEPTH) + 1;

   seq_state_t       state;
   logic [CNT_W-1:0] credits;
   logic [CNT_W-1:0] fifo_count;
   logic             fifo_full;
   logic             fifo_empty;
   logic             in_beat;
   logic             beat_xfer;
   logic             req_fire;
   logic             rd_accept;
   logic             resp_pop;

   // NOTE: the handshake outputs below are continuous assignments rather
   // than registers: ready/valid must follow the other side within the same
   // cycle, and a plain assign cannot infer a latch.
   assign in_beat        = !user_reset && (state == WBEAT0 || state == WBEAT1);
   assign app_wdf_enable = in_beat && wdata_valid;
   assign wdata_ready    = in_beat && app_wdf_ready;
   assign app_wdf_data   = in_beat ? wdata : '0;
   assign app_wdf_mask   = in_beat ? wmask : '0;
   assign beat_xfer      = app_wdf_enable && app_wdf_ready;

   // A read is only taken when a whole burst's worth of FIFO space is
   // already guaranteed; writes need no credits.
   assign req_ready = !user_reset && init_done && (state == IDLE) &&
                      (req_write || credits >= CNT_W'(BEATS_PER_BURST));
   assign req_fire  = req_valid && req_ready;
   assign rd_accept = req_fire && !req_write;

   assign resp_valid = !fifo_empty;
   assign resp_pop   = resp_valid && resp_ready;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // block samples the pre-edge values of the others.
   always_ff @(posedge user_clock) begin
      if (user_reset) begin
         state       <= IDLE;
         app_enable  <= 1'b0;
         app_cmd     <= CMD_WRITE;
         app_addr    <= '0;
         app_wdf_end <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_fire) begin
                  app_addr <= req_addr & ~ADDR_W'(7);
                  if (req_write) begin
                     app_cmd <= CMD_WRITE;
                     state   <= WBEAT0;
                  end else begin
                     app_cmd    <= CMD_READ;
                     app_enable <= 1'b1;
                     state      <= RCMD;
                  end
               end
            end
            WBEAT0: begin
               if (beat_xfer) begin
                  app_wdf_end <= 1'b1;
                  state       <= WBEAT1;
               end
            end
            WBEAT1: begin
               if (beat_xfer) begin
                  app_wdf_end <= 1'b0;
                  app_enable  <= 1'b1;
                  state       <= WCMD;
               end
            end
            WCMD, RCMD: begin
               if (app_ready) begin
                  app_enable <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Credits = free FIFO slots not yet promised to an issued read.
   always_ff @(posedge user_clock) begin
      if (user_reset) begin
         credits <= CNT_W'(RESP_DEPTH);
      end else begin
         case ({rd_accept, resp_pop})
            2'b10:   credits <= credits - CNT_W'(BEATS_PER_BURST);
            2'b01:   credits <= credits + CNT_W'(1);
            2'b11:   credits <= credits - CNT_W'(BEATS_PER_BURST - 1);
            default: ;
         endcase
      end
   end

   // Beats cannot be refused, so a push into a full FIFO with no pop that
   // cycle is lost and latched here until reset.
   always_ff @(posedge user_clock) begin
      if (user_reset) begin
         resp_overflow <= 1'b0;
      end else if (app_rd_ready && fifo_full && !resp_pop) begin
         resp_overflow <= 1'b1;
      end
   end

   // Promised slots plus stored beats can never exceed the FIFO depth.
   always_ff @(posedge user_clock) begin
      if (!user_reset) begin
         assert (int'(credits) + int'(fifo_count) <= RESP_DEPTH);
      end
   end

   ddr3_resp_fifo #(
      .DEPTH (RESP_DEPTH),
      .CNT_W (CNT_W)
   ) u_resp_fifo (
      .clk       (user_clock),
      .rst       (user_reset),
      .push      (app_rd_ready),
      .push_data (app_rd_data),
      .pop       (resp_pop),
      .pop_data  (resp_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

endmodule

// File: doc/ddr3_req_sequencer.md
# ddr3_req_sequencer

Request sequencer that sits directly upstream of the DDR3 controller wrapper and drives its user interface. It converts a ready/valid command stream plus a write-data stream into the controller's command and write-data handshakes, with two 256-bit beats per BL8 burst. Read beats are returned through a credit-protected response FIFO, because the controller's read-data port has no backpressure.

## Interface
Reset is synchronous and active-high. All ports are on one clock.

Parameters:
- RESP_DEPTH, 16: response FIFO depth in 256-bit beats; power of 2, at least 4.
- ADDR_W, 27: controller address width.

Ports:
- user_clock  in  1  controller user clock; all logic on this clock.
- user_reset  in  1  synchronous, active-high reset.
- req_valid  in  1  command request valid.
- req_write  in  1  1 = write burst, 0 = read burst.
- req_addr  in  ADDR_W  burst address; bits [2:0] ignored and driven as 0.
- req_ready  out  1  request accepted when req_valid && req_ready.
- wdata_valid  in  1  write beat valid.
- wdata  in  256  write beat data.
- wmask  in  32  byte mask; 1 = byte not written.
- wdata_ready  out  1  write beat accepted.
- resp_valid  out  1  read beat available.
- resp_data  out  256  read beat data.
- resp_ready  in  1  read beat consumed.
- resp_overflow  out  1  sticky error flag.
- app_cmd  out  3  controller command: 000 = write, 001 = read.
- app_enable  out  1  controller command valid.
- app_addr  out  ADDR_W  controller address.
- app_ready  in  1  controller command accept.
- app_wdf_enable  out  1  write-data valid.
- app_wdf_data  out  256  write-data beat.
- app_wdf_mask  out  32  write-data mask.
- app_wdf_end  out  1  last beat of burst.
- app_wdf_ready  in  1  write-data accept.
- app_rd_ready  in  1  read beat valid; no backpressure.
- app_rd_data  in  256  read beat data.
- init_done  in  1  controller calibration complete.

## Operation
- FSM states: IDLE, WBEAT0, WBEAT1, WCMD, RCMD.
- IDLE:
  - req_ready = init_done && (req_write || credits >= 2).
  - On acceptance, register the command with addr[2:0] forced to 0.
  - Write goes to WBEAT0; read goes to RCMD and reserves 2 credits that same cycle.
- WBEAT0:
  - app_wdf_enable = wdata_valid; wdata_ready = app_wdf_ready; app_wdf_end = 0.
  - Advance to WBEAT1 on wdata_valid && app_wdf_ready.
- WBEAT1: same handshake with app_wdf_end = 1; advance to WCMD on transfer.
- WCMD: app_enable = 1, app_cmd = 000; hold until app_ready, then go to IDLE.
- RCMD: app_enable = 1, app_cmd = 001; hold until app_ready, then go to IDLE.
- Command outputs (app_cmd, app_addr) and write-data outputs are stable while the corresponding enable is held and ready is low.
- Credits:
  - credits = RESP_DEPTH − FIFO occupancy − beats in flight.
  - Reset value is RESP_DEPTH.
  - −2 on read acceptance; +1 on each resp_valid && resp_ready.
  - Both events in one cycle give a net −1.
- Every app_rd_ready beat is pushed into the FIFO unconditionally.
- A push while the FIFO is full drops the beat and sets resp_overflow. It clears only on reset.
- wdata_ready is 0 outside WBEAT0/WBEAT1. Write beats are never buffered here.
- If init_done falls mid-operation: the current state holds and no new request is accepted. The wrapper's ready signals are already gated by init_done.

## Timing
- Reset values: FSM = IDLE; req_ready = 0 for the reset cycle; app_enable, app_wdf_enable, app_wdf_end, wdata_ready, resp_valid, resp_overflow = 0; app_cmd, app_addr, app_wdf_data, app_wdf_mask = 0; credits = RESP_DEPTH; FIFO empty.
- Reset mid-burst abandons the burst. The controller must be reset in the same cycle, since in-flight reads are lost.
- Minimum write is 4 cycles: accept, beat 0, beat 1, command.
- Minimum read issue is 2 cycles: accept, command.
- Read return: a beat on app_rd_ready in cycle N is visible on resp_valid in cycle N+1.
- resp_data is first-word order; beats come out in arrival order.
- The FIFO supports simultaneous push and pop when full, because pop frees the slot the same cycle.
- Back-to-back requests: IDLE is entered for at least 1 cycle between commands.

## Structure
- Shared package ddr3_seq_pkg holds:
  - CMD_WRITE = 3'b000 and CMD_READ = 3'b001.
  - The FSM state enum.
  - BEATS_PER_BURST = 2.
  - DATA_W = 256 and MASK_W = 32.
- Sub-module ddr3_resp_fifo holds the response buffer:
  - Synchronous, DATA_W wide, RESP_DEPTH deep.
  - Pointer-based with occupancy count.
  - Outputs full, empty and count.

## Test plan
- Write at addr 0x0000_00F: two beats 0xA…A / 0x5…5 with mask 0; app_ready stalls 3 cycles. Expected: app_addr = 0x0000008, app_wdf_end only on the second beat, app_cmd = 000 held stable through the stall.
- Read at addr 0x40 with app_rd_ready pulsing 2 beats at cycles 10 and 11. Expected: resp_valid in cycles 11 and 12 with matching data; credits return to 16 after both pops.
- RESP_DEPTH = 4, resp_ready = 0, three reads issued. Expected: the third read stalls with req_ready = 0 after 2 accepted; one pop gives credits 1, still stalled; a second pop re-opens acceptance.
- init_done = 0 for 20 cycles with req_valid = 1. Expected: req_ready = 0 and no app_enable. After init_done rises, the request is accepted the next cycle.
- Reset asserted in WBEAT1. Expected: the next cycle shows all outputs at reset values and the FSM in IDLE. A forced extra app_rd_ready into a full FIFO sets resp_overflow = 1, which persists until reset.
